// File: rtl/seq_scan_ctrl.sv
// Programmable serial pattern scanner: words arrive over valid/ready, shift MSB-first through a match window.
// Optional running hit total (total_o) is built when SEQ_SCAN_TOTAL_CNT_EN is defined.
module seq_scan_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = $clog2(DATA_W + 1),
    parameter int POS_W   = $clog2(DATA_W),
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk_i,
    input  logic               rstn,
    input  logic               cfg_we_i,
    input  logic [PAT_MAX-1:0] cfg_pat_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               clear_i,
    input  logic               in_valid_i,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [CNT_W-1:0]   out_count_o,
    output logic [POS_W-1:0]   out_pos_o,
    output logic               bit_o,
    output logic               hit_o
`ifdef SEQ_SCAN_TOTAL_CNT_EN
    ,
    output logic [15:0]        total_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Bit i of the mask is set when i lies inside the active pattern length.
    function automatic logic [PAT_MAX-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PAT_MAX-1:0] m;
        m = {PAT_MAX{1'b0}};
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < int'(len)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] r;
        if (len > LEN_W'(PAT_MAX)) begin
            r = LEN_W'(PAT_MAX);
        end else begin
            r = len;
        end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [POS_W-1:0]   idx_q, idx_d;
    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   seen_q, seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        total_q, total_d;

    logic               bit_s;
    logic               hit_s;
    logic [PAT_MAX-1:0] window_s;
    logic               enough_s;

    // Serial bit and Mealy match detection on the window that includes the current bit.
    always_comb begin
        if (state_q == ST_SHIFT) begin
            bit_s = word_q[DATA_W-1];
        end else begin
            bit_s = 1'b0;
        end
        window_s = {hist_q[PAT_MAX-2:0], bit_s};
        enough_s = (({1'b0, seen_q} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q});
        if ((state_q == ST_SHIFT) && (len_q != {LEN_W{1'b0}}) && enough_s) begin
            hit_s = (((window_s ^ pat_q) & len_mask(len_q)) == {PAT_MAX{1'b0}});
        end else begin
            hit_s = 1'b0;
        end
    end

    // Next-state and datapath updates for the IDLE/SHIFT/REPORT sequence.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        hist_d      = hist_q;
        seen_d      = seen_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        pat_d       = pat_q;
        len_d       = len_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        total_d     = total_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we_i) begin
                    pat_d = cfg_pat_i;
                    len_d = clamp_len(cfg_len_i);
                end else begin
                    pat_d = pat_q;
                    len_d = len_q;
                end
                if (clear_i) begin
                    hist_d  = {PAT_MAX{1'b0}};
                    seen_d  = {LEN_W{1'b0}};
                    total_d = 16'h0000;
                end else begin
                    hist_d  = hist_q;
                    seen_d  = seen_q;
                    total_d = total_q;
                end
                if (in_valid_i) begin
                    word_d     = in_data_i;
                    idx_d      = {POS_W{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    pos_d      = {POS_W{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_SHIFT;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                hist_d = window_s;
                word_d = {word_q[DATA_W-2:0], 1'b0};
                if (seen_q == LEN_W'(PAT_MAX)) begin
                    seen_d = seen_q;
                end else begin
                    seen_d = seen_q + LEN_W'(1);
                end
                if (hit_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        pos_d = idx_q;
                    end else begin
                        pos_d = pos_q;
                    end
                    if (total_q != 16'hFFFF) begin
                        total_d = total_q + 16'h0001;
                    end else begin
                        total_d = total_q;
                    end
                end else begin
                    cnt_d   = cnt_q;
                    pos_d   = pos_q;
                    total_d = total_q;
                end
                if (idx_q == POS_W'(DATA_W - 1)) begin
                    state_d     = ST_REPORT;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d   = idx_q + POS_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_REPORT: begin
                if (out_ready_i) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d     = ST_REPORT;
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            word_q      <= {DATA_W{1'b0}};
            idx_q       <= {POS_W{1'b0}};
            hist_q      <= {PAT_MAX{1'b0}};
            seen_q      <= {LEN_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            pos_q       <= {POS_W{1'b0}};
            pat_q       <= PAT_MAX'(4'b1010);
            len_q       <= LEN_W'(4);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            total_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            hist_q      <= hist_d;
            seen_q      <= seen_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            total_q     <= total_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_count_o = cnt_q;
    assign out_pos_o   = pos_q;
    assign bit_o       = bit_s;
    assign hit_o       = hit_s;

`ifdef SEQ_SCAN_TOTAL_CNT_EN
    assign total_o = total_q;
`else
    logic unused_total_s;
    assign unused_total_s = ^total_q;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus random words against a bit-stream reference model.
module tb_seq_scan_ctrl;
    localparam int DATA_W  = 8;
    localparam int PAT_MAX = 8;

    logic       clk_i = 1'b0;
    logic       rstn;
    logic       cfg_we_i;
    logic [7:0] cfg_pat_i;
    logic [3:0] cfg_len_i;
    logic       clear_i;
    logic       in_valid_i;
    logic [7:0] in_data_i;
    logic       in_ready_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [3:0] out_count_o;
    logic [2:0] out_pos_o;
    logic       bit_o;
    logic       hit_o;
`ifdef SEQ_SCAN_TOTAL_CNT_EN
    logic [15:0] total_o;
`endif

    seq_scan_ctrl dut (
        .clk_i      (clk_i),
        .rstn       (rstn),
        .cfg_we_i   (cfg_we_i),
        .cfg_pat_i  (cfg_pat_i),
        .cfg_len_i  (cfg_len_i),
        .clear_i    (clear_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_count_o(out_count_o),
        .out_pos_o  (out_pos_o),
        .bit_o      (bit_o),
        .hit_o      (hit_o)
`ifdef SEQ_SCAN_TOTAL_CNT_EN
        ,
        .total_o    (total_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the serial stream since the last clear/reset, newest bit at the back.
    bit         stream[$];
    logic [7:0] m_pat;
    int         m_len;
    int         m_total;

    function automatic void model_reset();
        stream.delete();
        m_pat   = 8'h0A;
        m_len   = 4;
        m_total = 0;
    endfunction

    function automatic bit model_hit();
        int n = stream.size();
        if (m_len == 0 || n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (stream[n-1-k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_word(input logic [7:0] data, input bit with_clr, input bit with_cfg,
                            input logic [7:0] pat, input int len, input int hold,
                            output int cnt, output int pos);
        int  exp_cnt;
        int  exp_pos;
        int  waited;
        bit  exp_bit;
        bit  exp_hit;
        waited = 0;
        while (in_ready_o !== 1'b1 && waited < 30) begin
            @(posedge clk_i); #1;
            waited++;
        end
        n_checks++;
        if (in_ready_o !== 1'b1) $display("FAIL accept_wait in_ready=%b required 1", in_ready_o);
        else n_pass++;
        in_valid_i = 1'b1;
        in_data_i  = data;
        cfg_we_i   = with_cfg;
        cfg_pat_i  = pat;
        cfg_len_i  = len[3:0];
        clear_i    = with_clr;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        cfg_we_i   = 1'b0;
        clear_i    = 1'b0;
        if (with_cfg) begin
            m_pat = pat;
            m_len = (len > PAT_MAX) ? PAT_MAX : len;
        end
        if (with_clr) begin
            stream.delete();
            m_total = 0;
        end
        exp_cnt = 0;
        exp_pos = 0;
        for (int i = 0; i < DATA_W; i++) begin
            exp_bit = data[DATA_W-1-i];
            stream.push_back(exp_bit);
            if (stream.size() > PAT_MAX) void'(stream.pop_front());
            exp_hit = model_hit();
            if (exp_hit) begin
                if (exp_cnt == 0) exp_pos = i;
                exp_cnt++;
                if (m_total < 65535) m_total++;
            end
            n_checks++;
            if (bit_o !== exp_bit || hit_o !== exp_hit || out_valid_o !== 1'b0 || in_ready_o !== 1'b0)
                $display("FAIL shift_idx%0d bit=%b hit=%b vld=%b rdy=%b required bit=%b hit=%b vld=0 rdy=0",
                         i, bit_o, hit_o, out_valid_o, in_ready_o, exp_bit, exp_hit);
            else n_pass++;
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (out_valid_o !== 1'b1 || out_count_o !== exp_cnt[3:0] || out_pos_o !== exp_pos[2:0])
            $display("FAIL result vld=%b cnt=%0d pos=%0d required vld=1 cnt=%0d pos=%0d",
                     out_valid_o, out_count_o, out_pos_o, exp_cnt, exp_pos);
        else n_pass++;
        cnt = out_count_o;
        pos = out_pos_o;
        for (int h = 0; h < hold; h++) begin
            cfg_we_i  = 1'b1;
            cfg_pat_i = ~m_pat;
            cfg_len_i = 4'd3;
            clear_i   = 1'b1;
            @(posedge clk_i); #1;
            n_checks++;
            if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || out_count_o !== exp_cnt[3:0] ||
                out_pos_o !== exp_pos[2:0] || bit_o !== 1'b0)
                $display("FAIL report_hold%0d vld=%b rdy=%b cnt=%0d pos=%0d required vld=1 rdy=0 cnt=%0d pos=%0d",
                         h, out_valid_o, in_ready_o, out_count_o, out_pos_o, exp_cnt, exp_pos);
            else n_pass++;
        end
        cfg_we_i    = 1'b0;
        clear_i     = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL release vld=%b rdy=%b required vld=0 rdy=1", out_valid_o, in_ready_o);
        else n_pass++;
`ifdef SEQ_SCAN_TOTAL_CNT_EN
        n_checks++;
        if (total_o !== m_total[15:0]) $display("FAIL total got=%0d required %0d", total_o, m_total);
        else n_pass++;
`endif
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        stream.delete();
        m_total = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rstn = 1'b1;
        model_reset();
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || bit_o !== 1'b0 || hit_o !== 1'b0 ||
            out_count_o !== 4'd0 || out_pos_o !== 3'd0)
            $display("FAIL reset_state rdy=%b vld=%b bit=%b hit=%b cnt=%0d pos=%0d required 1 0 0 0 0 0",
                     in_ready_o, out_valid_o, bit_o, hit_o, out_count_o, out_pos_o);
        else n_pass++;
    endtask

    task automatic test_default_pattern();
        int c, p;
        run_word(8'hAA, 1'b0, 1'b0, 8'h00, 0, 0, c, p);
        n_checks++;
        if (c != 3 || p != 3) $display("FAIL default_aa cnt=%0d pos=%0d required cnt=3 pos=3", c, p);
        else n_pass++;
    endtask

    task automatic test_boundary();
        int c, p;
        do_clear();
        run_word(8'h05, 1'b0, 1'b0, 8'h00, 0, 0, c, p);
        n_checks++;
        if (c != 0 || p != 0) $display("FAIL span_first cnt=%0d pos=%0d required 0 0", c, p);
        else n_pass++;
        run_word(8'h00, 1'b0, 1'b0, 8'h00, 0, 0, c, p);
        n_checks++;
        if (c != 1 || p != 0) $display("FAIL span_second cnt=%0d pos=%0d required 1 0", c, p);
        else n_pass++;
    endtask

    task automatic test_clear();
        int c, p;
        run_word(8'h05, 1'b0, 1'b0, 8'h00, 0, 0, c, p);
        do_clear();
        run_word(8'h00, 1'b0, 1'b0, 8'h00, 0, 0, c, p);
        n_checks++;
        if (c != 0) $display("FAIL clear_history cnt=%0d required 0", c);
        else n_pass++;
    endtask

    task automatic test_length();
        int c, p;
        run_word(8'hFF, 1'b0, 1'b1, 8'h07, 3, 0, c, p);
        n_checks++;
        if (c != 6 || p != 2) $display("FAIL len3_ones cnt=%0d pos=%0d required 6 2", c, p);
        else n_pass++;
        run_word(8'hFF, 1'b0, 1'b1, 8'h07, 0, 0, c, p);
        n_checks++;
        if (c != 0) $display("FAIL len0 cnt=%0d required 0", c);
        else n_pass++;
        run_word(8'hC3, 1'b1, 1'b1, 8'hC3, 12, 0, c, p);
        n_checks++;
        if (c != 1 || p != 7) $display("FAIL len_clamp cnt=%0d pos=%0d required 1 7", c, p);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int c, p;
        run_word(8'h00, 1'b1, 1'b1, 8'h0A, 4, 0, c, p);
        run_word(8'hAA, 1'b0, 1'b0, 8'h00, 0, 5, c, p);
        run_word(8'hAA, 1'b0, 1'b0, 8'h00, 0, 0, c, p);
        n_checks++;
        if (c != 4 || p != 1) $display("FAIL cfg_ignored_report cnt=%0d pos=%0d required 4 1", c, p);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c, p;
        bit saw_valid;
        in_valid_i = 1'b1;
        in_data_i  = 8'hAA;
        cfg_we_i   = 1'b1;
        cfg_pat_i  = 8'h07;
        cfg_len_i  = 4'd3;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        cfg_we_i   = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        rstn = 1'b0;
        @(posedge clk_i); #1;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || bit_o !== 1'b0 || hit_o !== 1'b0)
            $display("FAIL reset_mid rdy=%b vld=%b bit=%b hit=%b required 1 0 0 0",
                     in_ready_o, out_valid_o, bit_o, hit_o);
        else n_pass++;
        rstn = 1'b1;
        model_reset();
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            if (out_valid_o !== 1'b0) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) $display("FAIL reset_mid_no_result saw out_valid=1 required 0");
        else n_pass++;
        run_word(8'hAA, 1'b0, 1'b0, 8'h00, 0, 0, c, p);
        n_checks++;
        if (c != 3 || p != 3) $display("FAIL reset_mid_pattern cnt=%0d pos=%0d required 3 3", c, p);
        else n_pass++;
    endtask

    task automatic test_random();
        int c, p;
        logic [7:0] d;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = 8'hAA ^ 8'($urandom_range(0, 3));
            run_word(d, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                     8'($urandom), int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), c, p);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        cfg_we_i    = 1'b0;
        cfg_pat_i   = 8'h00;
        cfg_len_i   = 4'd0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        out_ready_i = 1'b0;
        model_reset();
        test_reset();
        test_default_pattern();
        test_boundary();
        test_clear();
        test_length();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Controller that sequences a programmable serial pattern matcher, the configurable successor to the fixed 1010 detector.
- Accepts parallel words over a valid/ready handshake and shifts each word MSB-first, one bit per clock, through an internal match datapath.
- Reports per-word match count and first-match position over a valid/ready output.
- Sits between a word-oriented producer and a status/consumer interface; pattern is configured at runtime while idle.

Parameters:
- DATA_W, 8, bits per input word.
- PAT_MAX, 8, maximum pattern length in bits; sizes history and pattern registers.
- CNT_W, $clog2(DATA_W+1) = 4, width of the per-word match count.
- POS_W, $clog2(DATA_W) = 3, width of the first-match position.
- LEN_W, $clog2(PAT_MAX+1) = 4, width of the pattern-length field.

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- rstn  in  1  reset, synchronous and active-low.
- cfg_we_i  in  1  pattern write strobe.
- cfg_pat_i  in  PAT_MAX  pattern value; bit [len-1] is the first bit in time.
- cfg_len_i  in  LEN_W  pattern length.
- clear_i  in  1  clear the stream history.
- in_valid_i  in  1  input word valid.
- in_data_i  in  DATA_W  input word.
- in_ready_o  out  1  controller can accept a word.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- out_count_o  out  CNT_W  matches completed within the word.
- out_pos_o  out  POS_W  bit index (0 = MSB) where the first match completed; 0 when out_count_o = 0.
- bit_o  out  1  serial bit presented this cycle; 0 outside SHIFT.
- hit_o  out  1  Mealy hit: the current bit_o completes a match.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - state = IDLE; history, bits-seen counter, bit index, count and position cleared.
  - pattern = 4'b1010, length = 4.
  - out_valid_o = 0, in_ready_o = 1, bit_o = 0, hit_o = 0.
  - Reset during SHIFT or REPORT aborts: the word is dropped and no result is issued.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready_o = 1.
  - in_valid_i = 1 at an edge: latch in_data_i, bit index = 0, count = 0, go to SHIFT.
  - cfg_we_i: load pattern and length at the edge. If it coincides with acceptance, the new pattern applies to that word.
  - clear_i: history and bits-seen counter cleared at the edge. If it coincides with acceptance, the word starts from an empty history.
- SHIFT:
  - in_ready_o = 0; bit_o = word bit [DATA_W-1-idx].
  - At each edge, history shifts left with bit_o and bits-seen increments, saturating at PAT_MAX.
  - hit_o is combinational: (len != 0) and (bits-seen+1 >= len) and (low len bits of {history, bit_o} == pattern[len-1:0]).
  - On hit_o: count increments; if this is the first hit of the word, position = idx.
  - Overlapping matches are counted.
  - After idx = DATA_W-1 the FSM goes to REPORT, so out_valid_o rises exactly DATA_W edges after the accepting edge.
  - cfg_we_i and clear_i are ignored in SHIFT.
- REPORT:
  - out_valid_o = 1; count and position held stable until out_ready_i = 1 at an edge, then return to IDLE.
  - in_ready_o = 0; cfg_we_i and clear_i are ignored.
  - Minimum word period: DATA_W+2 cycles.
- History persists across words, so matches may span a word boundary; only clear_i or reset resets it.
- Length rules: len = 0 never matches; len > PAT_MAX is clamped to PAT_MAX at load.
- out_ready_i while out_valid_o = 0 has no effect.
- Count cannot overflow, since at most DATA_W hits occur per word.

Optional Feature:
- Macro: SEQ_SCAN_TOTAL_CNT_EN.
- Defined: adds output total_o [15:0], a running total of all hits since reset or clear_i.
  - Saturates at 16'hFFFF.
  - Updates on the edge following each hit_o.
  - Clears on reset and on an accepted clear_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Default pattern 1010, word 8'hAA -> out_count_o = 3, out_pos_o = 3; out_valid_o rises 8 edges after acceptance; hit_o pulses at idx 3, 5, 7.
- Word 8'h05 then word 8'h00, no clear -> first result count 0, pos 0; second result count 1, pos 0 (match spans the boundary).
- Same two words with clear_i asserted in IDLE before the second word -> second result count 0.
- cfg_len_i = 3, cfg_pat_i = 3'b111, word 8'hFF -> count 6, pos 2. Then cfg_len_i = 0 with word 8'hFF -> count 0.
- Hold out_ready_i = 0 for 5 cycles in REPORT -> out_valid_o, out_count_o and out_pos_o stable, in_ready_o = 0, cfg_we_i ignored (pattern unchanged on the next word).
- rstn = 0 during SHIFT at idx 4 -> next edge state IDLE, in_ready_o = 1, pattern back to 1010, no out_valid_o pulse ever for that word.
